funct_waveform_gen: RTL and testbench

- Waveform sample engine that sits directly downstream of the generator parameter registers (frequency-step, amplitude and wave-select registers).
- A phase accumulator drives a shape function: sawtooth, square, triangle or DC.
- Each shape value is scaled by the latched amplitude.
- Samples are pushed over a valid/ready handshake into the downstream sample FIFO.

---
 rtl/gen_fifo_defines_pkg.sv | 19 +
 rtl/funct_waveform_gen_if.sv | 12 +
 rtl/funct_wave_shaper.sv | 30 +++
 rtl/funct_waveform_gen.sv | 112 +++++++++++
 tb/tb_funct_waveform_gen.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gen_fifo_defines_pkg.sv
// Shared types for the waveform generator: wave selector, FSM states and the
// default sample width.
package gen_fifo_defines_pkg;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    WAVE_SAW = 2'b00,
    WAVE_SQR = 2'b01,
    WAVE_TRI = 2'b10,
    WAVE_DC  = 2'b11
  } wave_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    RUN   = 2'b10,
    DRAIN = 2'b11
  } gen_state_e;
endpackage

// File: rtl/funct_waveform_gen_if.sv
// Sample stream towards the downstream FIFO. A sample moves on any cycle with
// out_valid && out_ready; once raised, out_valid and out_data hold until then.
interface funct_waveform_gen_if #(
  parameter int DATA_WIDTH = gen_fifo_defines_pkg::DATA_WIDTH
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/funct_wave_shaper.sv
// Combinational shape function of the phase, scaled by the amplitude and
// keeping the upper half of the full-width product.
module funct_wave_shaper
  import gen_fifo_defines_pkg::*;
#(
  parameter int DATA_WIDTH = gen_fifo_defines_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] phase,
  input  wave_e                 wave_sel,
  input  logic [DATA_WIDTH-1:0] amp,
  output logic [DATA_WIDTH-1:0] sample
);
  logic [DATA_WIDTH-1:0]   shape;
  logic [DATA_WIDTH-1:0]   tri_t;
  logic [2*DATA_WIDTH-1:0] prod;

  always_comb begin
    shape = '0;
    tri_t = {phase[DATA_WIDTH-2:0], 1'b0};
    case (wave_sel)
      WAVE_SAW: shape = phase;
      WAVE_SQR: shape = phase[DATA_WIDTH-1] ? '1 : '0;
      WAVE_TRI: shape = phase[DATA_WIDTH-1] ? ~tri_t : tri_t;
      WAVE_DC:  shape = '1;
      default:  shape = '0;
    endcase
    prod   = {{DATA_WIDTH{1'b0}}, shape} * {{DATA_WIDTH{1'b0}}, amp};
    sample = prod[2*DATA_WIDTH-1:DATA_WIDTH];
  end
endmodule

// File: rtl/funct_waveform_gen.sv
// Waveform sample engine: phase accumulator and shaper feeding a registered
// valid/ready output, controlled by an IDLE/LOAD/RUN/DRAIN state machine.
module funct_waveform_gen
  import gen_fifo_defines_pkg::*;
#(
  parameter int DATA_WIDTH = gen_fifo_defines_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic [1:0]                  wave_sel,
  input  logic [DATA_WIDTH-1:0]       freq_step,
  input  logic [DATA_WIDTH-1:0]       amp,
  funct_waveform_gen_if.master        out_if,
  output logic                        busy,
  output logic [CNT_WIDTH-1:0]        sample_cnt,
  output gen_state_e                  state_dbg
);
  gen_state_e            state, state_n;
  logic                  valid_q, valid_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic [DATA_WIDTH-1:0] phase_q, phase_n;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_n;
  logic [DATA_WIDTH-1:0] step_sh, step_sh_n;
  logic [DATA_WIDTH-1:0] amp_sh, amp_sh_n;
  wave_e                 sel_sh, sel_sh_n;
  logic [DATA_WIDTH-1:0] sample;

  funct_wave_shaper #(.DATA_WIDTH(DATA_WIDTH)) u_shaper (
    .phase    (phase_q),
    .wave_sel (sel_sh),
    .amp      (amp_sh),
    .sample   (sample)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
      step_sh <= '0;
      amp_sh  <= '0;
      sel_sh  <= WAVE_SAW;
    end else begin
      state   <= state_n;
      valid_q <= valid_n;
      data_q  <= data_n;
      phase_q <= phase_n;
      cnt_q   <= cnt_n;
      step_sh <= step_sh_n;
      amp_sh  <= amp_sh_n;
      sel_sh  <= sel_sh_n;
    end
  end

  always_comb begin
    state_n   = state;
    valid_n   = valid_q;
    data_n    = data_q;
    phase_n   = phase_q;
    cnt_n     = cnt_q;
    step_sh_n = step_sh;
    amp_sh_n  = amp_sh;
    sel_sh_n  = sel_sh;
    if (valid_q && out_if.out_ready) cnt_n = cnt_q + 1'b1;
    case (state)
      IDLE: begin
        if (start && !stop) state_n = LOAD;
      end
      LOAD: begin
        step_sh_n = freq_step;
        amp_sh_n  = amp;
        sel_sh_n  = wave_e'(wave_sel);
        phase_n   = '0;
        cnt_n     = '0;
        state_n   = RUN;
      end
      RUN: begin
        // stop suppresses the new sample; a stalled sample must still drain
        if (stop) begin
          if (valid_q && !out_if.out_ready) begin
            state_n = DRAIN;
          end else begin
            valid_n = 1'b0;
            state_n = IDLE;
          end
        end else if (!valid_q || out_if.out_ready) begin
          data_n  = sample;
          valid_n = 1'b1;
          phase_n = phase_q + step_sh;
        end
      end
      DRAIN: begin
        if (out_if.out_ready) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign busy             = (state != IDLE);
  assign sample_cnt       = cnt_q;
  assign state_dbg        = state;
endmodule

// File: tb/tb_funct_waveform_gen.sv
// Randomized and directed bench for funct_waveform_gen with an expected-sample
// queue filled from an arithmetic model of the waveform definitions.
module tb_funct_waveform_gen;
  import gen_fifo_defines_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic         stop;
  logic [1:0]   wave_sel;
  logic [W-1:0] freq_step;
  logic [W-1:0] amp;
  logic         busy;
  logic [15:0]  sample_cnt;
  gen_state_e   state_dbg;

  funct_waveform_gen_if #(.DATA_WIDTH(W)) wif ();

  funct_waveform_gen #(.DATA_WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .wave_sel   (wave_sel),
    .freq_step  (freq_step),
    .amp        (amp),
    .out_if     (wif),
    .busy       (busy),
    .sample_cnt (sample_cnt),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned  checks;
  int unsigned  failures;
  logic [W-1:0] exp_q[$];
  logic [15:0]  tb_cnt;
  logic         stall_prev;
  logic [W-1:0] stall_data;

  logic [W-1:0] saw_tab[8] = '{16'h0000, 16'h0800, 16'h1000, 16'h1800,
                               16'h2000, 16'h2800, 16'h3000, 16'h3800};
  logic [W-1:0] sqr_tab[8] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF,
                               16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF};
  logic [W-1:0] tri_tab[8] = '{16'h0000, 16'h4000, 16'h7FFF, 16'h3FFF,
                               16'h0000, 16'h4000, 16'h7FFF, 16'h3FFF};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // sample number k after a start, straight from the waveform definitions
  function automatic logic [W-1:0] model_sample(input int unsigned sel, input longint unsigned k,
                                                input longint unsigned step, input longint unsigned a);
    longint unsigned full, half, ph, shp;
    full = 64'd1 << W;
    half = full / 2;
    ph   = (k * step) % full;
    case (sel)
      0:       shp = ph;
      1:       shp = (ph >= half) ? full - 1 : 0;
      2:       shp = (ph < half) ? 2 * ph : (full - 1) - 2 * (ph - half);
      default: shp = full - 1;
    endcase
    return W'((shp * a) >> W);
  endfunction

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", wif.out_valid, 1);
        check("hold_data", wif.out_data, stall_data);
      end
      if (wif.out_valid && wif.out_ready) begin
        check("cnt_at_xfer", sample_cnt, tb_cnt);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_xfer got=%0h exp=none", wif.out_data);
        end else begin
          check("sample", wif.out_data, exp_q.pop_front());
        end
        tb_cnt = tb_cnt + 1'b1;
      end
      stall_prev = wif.out_valid && !wif.out_ready;
      stall_data = wif.out_data;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cfg(input int unsigned sel, input logic [W-1:0] step, input logic [W-1:0] a,
                         input bit use_model);
    wave_sel  = 2'(sel);
    freq_step = step;
    amp       = a;
    exp_q.delete();
    if (use_model)
      for (int k = 0; k < 64; k++) exp_q.push_back(model_sample(sel, k, step, a));
  endtask

  task automatic push_tab(input logic [W-1:0] tab[8]);
    foreach (tab[i]) exp_q.push_back(tab[i]);
  endtask

  task automatic start_gen();
    tb_cnt        = '0;
    wif.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("lat_load_valid", wif.out_valid, 0);
    check("lat_load_busy", busy, 1);
    tick();
    @(negedge clk);
    check("lat_n1_valid", wif.out_valid, 0);
    tick();
    @(negedge clk);
    check("lat_first_valid", wif.out_valid, 1);
  endtask

  task automatic wait_xfers(input int n);
    int guard;
    guard = 0;
    while (tb_cnt < 16'(n) && guard < 400) begin
      tick();
      guard++;
    end
    if (guard >= 400) check("wait_xfers_timeout", tb_cnt, 16'(n));
  endtask

  task automatic wait_idle(input bit rnd_ready);
    int guard;
    guard = 0;
    while (busy && guard < 200) begin
      if (rnd_ready) wif.out_ready = ($urandom_range(0, 1) == 1);
      else           wif.out_ready = 1'b1;
      tick();
      guard++;
    end
    if (guard >= 200) check("wait_idle_timeout", busy, 0);
  endtask

  task automatic stop_gen(input bit rnd_ready);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle(rnd_ready);
    @(negedge clk);
    check("idle_valid", wif.out_valid, 0);
    check("idle_cnt", sample_cnt, tb_cnt);
  endtask

  initial begin
    logic [15:0]  held_cnt;
    logic [W-1:0] held_data;
    int           target;
    int           guard;
    checks = 0; failures = 0; tb_cnt = '0;
    stall_prev = 1'b0; stall_data = '0;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    wave_sel = '0; freq_step = '0; amp = '0; wif.out_ready = 1'b0;

    // reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", wif.out_valid, 0);
    check("rst_data", wif.out_data, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_cnt", sample_cnt, 0);
    check("rst_state", state_dbg, IDLE);
    rst = 1'b0;
    tick();

    // start together with stop stays idle
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    @(negedge clk);
    check("start_stop_busy", busy, 0);

    // saw
    set_cfg(0, 16'h1000, 16'h8000, 1'b0);
    push_tab(saw_tab);
    start_gen();
    wait_xfers(4);
    stop_gen(1'b0);

    // square
    set_cfg(1, 16'h4000, 16'h8000, 1'b0);
    push_tab(sqr_tab);
    start_gen();
    wait_xfers(6);
    stop_gen(1'b0);

    // triangle, count after four transfers
    set_cfg(2, 16'h4000, 16'h8000, 1'b0);
    push_tab(tri_tab);
    start_gen();
    wait_xfers(4);
    wif.out_ready = 1'b0;
    @(negedge clk);
    check("tri_cnt4", sample_cnt, 4);
    stop_gen(1'b0);

    // backpressure: three stalled cycles, then the sequence continues
    set_cfg(0, 16'h1000, 16'h8000, 1'b0);
    push_tab(saw_tab);
    start_gen();
    wait_xfers(2);
    wif.out_ready = 1'b0;
    @(negedge clk);
    held_cnt  = sample_cnt;
    held_data = wif.out_data;
    check("bp_cnt_start", held_cnt, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("bp_cnt_frozen", sample_cnt, held_cnt);
      check("bp_data_frozen", wif.out_data, held_data);
    end
    wif.out_ready = 1'b1;
    wait_xfers(6);
    stop_gen(1'b0);

    // stop during stall drains; parameter changes mid-run are ignored
    set_cfg(0, 16'h1000, 16'h8000, 1'b0);
    push_tab(saw_tab);
    start_gen();
    wait_xfers(3);
    amp = 16'hFFFF; wave_sel = 2'b11; freq_step = 16'h0123;
    wait_xfers(5);
    wif.out_ready = 1'b0;
    tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    @(negedge clk);
    check("drain_state", state_dbg, DRAIN);
    check("drain_busy", busy, 1);
    check("drain_valid", wif.out_valid, 1);
    tick();
    @(negedge clk);
    check("drain_hold_state", state_dbg, DRAIN);
    wif.out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("drain_done_valid", wif.out_valid, 0);
    check("drain_done_busy", busy, 0);
    check("drain_done_cnt", sample_cnt, tb_cnt);

    // the new parameters apply from the next start
    set_cfg(3, 16'h0123, 16'hFFFF, 1'b1);
    start_gen();
    wait_xfers(3);
    stop_gen(1'b0);

    // randomized runs with random backpressure and ignored input activity
    for (int r = 0; r < 8; r++) begin
      set_cfg($urandom_range(0, 3), 16'($urandom), 16'($urandom), 1'b1);
      start_gen();
      target = $urandom_range(5, 30);
      guard  = 0;
      while (tb_cnt < 16'(target) && guard < 600) begin
        wif.out_ready = ($urandom_range(0, 3) != 0);
        start         = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 5) == 0) begin
          amp       = 16'($urandom);
          freq_step = 16'($urandom);
          wave_sel  = 2'($urandom_range(0, 3));
        end
        tick();
        guard++;
      end
      start = 1'b0;
      if (guard >= 600) check("rand_run_timeout", tb_cnt, 16'(target));
      stop_gen(1'b1);
    end

    // reset in mid-run discards the pending sample
    set_cfg(2, 16'($urandom), 16'($urandom), 1'b1);
    start_gen();
    wait_xfers(3);
    wif.out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("mid_rst_valid", wif.out_valid, 0);
    check("mid_rst_data", wif.out_data, 16'h0000);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cnt", sample_cnt, 0);
    rst = 1'b0;
    exp_q.delete();
    tb_cnt = '0;
    tick();
    tick();
    @(negedge clk);
    check("post_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
